// File: rtl/led_pio_pkg.sv
// Shared register-map constants and PWM sizing for the LED PIO slave.
package led_pio_pkg;

   typedef enum logic [2:0] {
      ADDR_DATA         = 3'd0,
      ADDR_BLINK_MASK   = 3'd1,
      ADDR_BLINK_PERIOD = 3'd2,
      ADDR_PWM_DUTY     = 3'd3,
      ADDR_OUTSET       = 3'd4,
      ADDR_OUTCLEAR     = 3'd5
   } reg_addr_e;

   localparam int unsigned          PWM_WIDTH = 8;
   localparam logic [PWM_WIDTH-1:0] PWM_FULL  = 8'hFF;

endpackage

// File: rtl/led_blink_timer.sv
// Blink half-period timer: down-counter with reload and a phase bit that
// starts high and toggles each time the counter expires.
module led_blink_timer #(
   parameter int unsigned CNT_WIDTH = 24
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [CNT_WIDTH-1:0] period,
   input  logic                 load,
   output logic                 phase
);

   logic [CNT_WIDTH-1:0] cnt;

   // A period load beats a coincident terminal count; a zero period parks
   // the timer with phase high so masked LEDs stay lit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt   <= '0;
         phase <= 1'b1;
      end else if (load) begin
         cnt   <= period;
         phase <= 1'b1;
      end else if (period == '0) begin
         cnt   <= '0;
         phase <= 1'b1;
      end else if (cnt == '0) begin
         cnt   <= period;
         phase <= ~phase;
      end else begin
         cnt   <= cnt - CNT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/avalon_led_pio.sv
// Avalon-MM zero-wait-state LED output PIO with set/clear, per-bit blink and
// an optional PWM dimmer enabled by defining LED_PIO_PWM_EN.
module avalon_led_pio
   import led_pio_pkg::*;
#(
   parameter int unsigned            DATA_WIDTH  = 4,
   parameter int unsigned            CNT_WIDTH   = 24,
   parameter logic [DATA_WIDTH-1:0]  RESET_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [2:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   output logic [DATA_WIDTH-1:0] out_port
);

   logic                  wr;
   logic [DATA_WIDTH-1:0] data;
   logic [DATA_WIDTH-1:0] blink_mask;
   logic [CNT_WIDTH-1:0]  blink_period;
   logic [CNT_WIDTH-1:0]  period_in;
   logic                  blink_load;
   logic                  phase;
   logic                  pwm_gate;
   logic                  unused_wdata;

   assign wr           = chipselect & ~write_n;
   assign blink_load   = wr && (address == ADDR_BLINK_PERIOD);
   assign unused_wdata = ^writedata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data         <= RESET_VALUE;
         blink_mask   <= '0;
         blink_period <= '0;
      end else if (wr) begin
         case (address)
            ADDR_DATA:         data         <= writedata[DATA_WIDTH-1:0];
            ADDR_BLINK_MASK:   blink_mask   <= writedata[DATA_WIDTH-1:0];
            ADDR_BLINK_PERIOD: blink_period <= writedata[CNT_WIDTH-1:0];
            ADDR_OUTSET:       data         <= data | writedata[DATA_WIDTH-1:0];
            ADDR_OUTCLEAR:     data         <= data & ~writedata[DATA_WIDTH-1:0];
            default: ;
         endcase
      end
   end

   // The timer sees the incoming value on the load edge so it reloads with it.
   assign period_in = blink_load ? writedata[CNT_WIDTH-1:0] : blink_period;

   led_blink_timer #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_blink (
      .clk     (clk),
      .reset_n (reset_n),
      .period  (period_in),
      .load    (blink_load),
      .phase   (phase)
   );

`ifdef LED_PIO_PWM_EN
   logic [PWM_WIDTH-1:0] pwm_duty;
   logic [PWM_WIDTH-1:0] pwm_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pwm_duty <= PWM_FULL;
         pwm_cnt  <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_WIDTH'(1);
         if (wr && (address == ADDR_PWM_DUTY)) begin
            pwm_duty <= writedata[PWM_WIDTH-1:0];
         end
      end
   end

   assign pwm_gate = (pwm_duty == PWM_FULL) || (pwm_cnt < pwm_duty);
`else
   assign pwm_gate = 1'b1;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_port <= RESET_VALUE;
      end else begin
         out_port <= data & (~blink_mask | {DATA_WIDTH{phase}}) & {DATA_WIDTH{pwm_gate}};
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:         readdata[DATA_WIDTH-1:0] = data;
         ADDR_BLINK_MASK:   readdata[DATA_WIDTH-1:0] = blink_mask;
         ADDR_BLINK_PERIOD: readdata[CNT_WIDTH-1:0]  = blink_period;
`ifdef LED_PIO_PWM_EN
         ADDR_PWM_DUTY:     readdata[PWM_WIDTH-1:0]  = pwm_duty;
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_avalon_led_pio.sv
// Scoreboard bench for avalon_led_pio: a behavioural model predicts out_port
// every cycle and readdata on each read; a monitor compares on falling edges.
module tb_avalon_led_pio;

   localparam int unsigned   DW = 4;
   localparam int unsigned   CW = 24;
   localparam logic [DW-1:0] RV = 4'b0101;
   localparam longint unsigned PMASK = (64'd1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [2:0]    address = '0;
   logic          chipselect = 1'b0;
   logic          write_n = 1'b1;
   logic [31:0]   writedata = '0;
   logic [31:0]   readdata;
   logic [DW-1:0] out_port;

   avalon_led_pio #(
      .DATA_WIDTH  (DW),
      .CNT_WIDTH   (CW),
      .RESET_VALUE (RV)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endfunction

   // Reference model state: register contents plus elapsed-edge counts.
   logic [DW-1:0]   m_data = RV;
   logic [DW-1:0]   m_mask = '0;
   longint unsigned m_period = 0;
   int unsigned     m_duty = 255;
   longint unsigned t_load = 0;
   longint unsigned n_rst = 0;

   typedef struct {
      logic [2:0]  a;
      logic [31:0] v;
   } rd_t;

   logic [DW-1:0] out_q[$];
   rd_t           rd_q[$];

   function automatic logic [31:0] model_read(logic [2:0] a);
      case (a)
         3'd0: return 32'(m_data);
         3'd1: return 32'(m_mask);
         3'd2: return 32'(m_period);
`ifdef LED_PIO_PWM_EN
         3'd3: return 32'(m_duty);
`endif
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk or negedge reset_n) begin
      bit            ph;
      bit            gate;
      logic [DW-1:0] e;
      rd_t           r;
      if (!reset_n) begin
         m_data = RV; m_mask = '0; m_period = 0; m_duty = 255;
         t_load = 0; n_rst = 0;
         if (clk) out_q.push_back(RV);
      end else begin
         // LED i is lit when its data bit is set, it is not in a dark blink
         // half-period, and the dimmer is in its on window.
         ph = (m_period == 0) ? 1'b1 : (((t_load / (m_period + 1)) % 2) == 0);
`ifdef LED_PIO_PWM_EN
         gate = (m_duty == 255) || ((n_rst % 256) < m_duty);
`else
         gate = 1'b1;
`endif
         e = m_data & (~m_mask | (ph ? {DW{1'b1}} : {DW{1'b0}}));
         if (!gate) e = '0;
         out_q.push_back(e);
         t_load++;
         n_rst++;
         if (chipselect && !write_n) begin
            case (address)
               3'd0: m_data = writedata[DW-1:0];
               3'd1: m_mask = writedata[DW-1:0];
               3'd2: begin m_period = writedata & PMASK; t_load = 0; end
`ifdef LED_PIO_PWM_EN
               3'd3: m_duty = writedata[7:0];
`endif
               3'd4: m_data = m_data | writedata[DW-1:0];
               3'd5: m_data = m_data & ~writedata[DW-1:0];
               default: ;
            endcase
         end
         if (chipselect && write_n) begin
            r.a = address;
            r.v = model_read(address);
            rd_q.push_back(r);
         end
      end
   end

   always @(negedge clk) begin
      logic [DW-1:0] e;
      rd_t           r;
      if (out_q.size() > 0) begin
         e = out_q.pop_front();
         check("out_port", 32'(out_port), 32'(e));
      end
      if (rd_q.size() > 0) begin
         r = rd_q.pop_front();
         check($sformatf("readdata[a=%0d]", r.a), readdata, r.v);
      end
   end

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk); #1;
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
   endtask

   task automatic rd(input logic [2:0] a);
      @(negedge clk); #1;
      chipselect = 1'b1; write_n = 1'b1; address = a; writedata = $urandom;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk); #1;
         chipselect = 1'b0; write_n = 1'($urandom_range(0, 1));
         address = 3'($urandom_range(0, 7)); writedata = $urandom;
      end
   endtask

   initial begin
      logic [2:0]  a;
      logic [31:0] d;
      repeat (2) @(negedge clk);
      #1 reset_n = 1'b1;

      for (int i = 0; i < 8; i++) rd(3'(i));

      wr(3'd0, 32'hA); idle(1); rd(3'd0);
      wr(3'd4, 32'h1); rd(3'd0);
      wr(3'd5, 32'h8); rd(3'd0);
      wr(3'd0, 32'hFFFF_FFF0); rd(3'd0);

      wr(3'd0, 32'hF); wr(3'd1, 32'h3); wr(3'd2, 32'd3); idle(20);

      wr(3'd2, 32'd3); idle(3); wr(3'd2, 32'd5); rd(3'd2); idle(15);
      wr(3'd2, 32'd0); idle(6);

      wr(3'd1, 32'h0); wr(3'd0, 32'h1);
      wr(3'd3, 32'd64); idle(520); rd(3'd3);
      wr(3'd3, 32'd0); idle(260);
      wr(3'd3, 32'hFF); idle(20); rd(3'd3);

      wr(3'd6, 32'hFFFF_FFFF); wr(3'd7, 32'h0); rd(3'd6); rd(3'd7); rd(3'd0);

      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0: rd(3'($urandom_range(0, 7)));
            1: idle(1);
            default: begin
               a = 3'($urandom_range(0, 7));
               d = (a == 3'd2) ? 32'($urandom_range(0, 6)) : $urandom;
               wr(a, d);
            end
         endcase
      end

      wr(3'd0, 32'hF); wr(3'd1, 32'h3); wr(3'd3, 32'hFF); wr(3'd2, 32'd2); idle(7);
      @(negedge clk); #1;
      chipselect = 1'b0;
      reset_n = 1'b0;
      #1 check("async_reset_out", 32'(out_port), 32'(RV));
      #1 reset_n = 1'b1;
      check("reset_release_out", 32'(out_port), 32'(RV));
      rd(3'd1); rd(3'd0); idle(10);

      idle(2);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
